// File: rtl/irq_ctl.sv
// Memory-mapped interrupt controller: 8 maskable sources (level/edge) plus one
// rising-edge NMI, with PEND/ENABLE/EDGE/STATUS registers on the CPU bus.
module irq_ctl #(
    parameter logic [15:0] BASE         = 16'hFE00,
    parameter logic [7:0]  RESET_ENABLE = 8'h00
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] AD,
    input  logic [7:0]  DO,
    input  logic        WE,
    input  logic        RDY,
    input  logic [7:0]  src,
    input  logic        nmi_src,
    output logic [7:0]  DI,
    output logic        sel,
    output logic        IRQ,
    output logic        NMI
);

    typedef enum logic [1:0] {
        R_PEND   = 2'd0,
        R_ENABLE = 2'd1,
        R_EDGE   = 2'd2,
        R_STATUS = 2'd3
    } reg_e;

    logic [7:0] pend_q, pend_d;
    logic [7:0] enable_q, enable_d;
    logic [7:0] edge_q, edge_d;
    logic [7:0] src_q;
    logic       nmi_q;
    logic       nmi_pend_q, nmi_pend_d;
    logic [7:0] di_q, di_d;
    logic       sel_q, sel_d;
    logic       irq_q, nmi_out_q;

    logic       hit, wr, rd;
    reg_e       ridx;
    logic [7:0] rise, w1c, mode_chg, act, status;
    logic       nmi_rise;
    logic [2:0] idx;

    assign hit      = (AD[15:2] == BASE[15:2]);
    assign ridx     = reg_e'(AD[1:0]);
    assign wr       = hit & WE & RDY;
    assign rd       = hit & ~WE;
    assign rise     = src & ~src_q;
    assign nmi_rise = nmi_src & ~nmi_q;
    assign act      = pend_q & enable_q;

    always_comb begin
        idx = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (act[i-1]) idx = 3'(i - 1);
        end
    end

    assign status = {nmi_pend_q, 3'b000, |act, idx};

    always_comb begin
        w1c        = '0;
        mode_chg   = '0;
        enable_d   = enable_q;
        edge_d     = edge_q;
        nmi_pend_d = nmi_pend_q | nmi_rise;
        if (wr) begin
            unique case (ridx)
                R_PEND:   w1c = DO;
                R_ENABLE: enable_d = DO;
                R_EDGE: begin
                    edge_d   = DO;
                    mode_chg = DO ^ edge_q;
                end
                R_STATUS: if (DO[7]) nmi_pend_d = nmi_rise;
            endcase
        end
    end

    // Mode is judged on the pre-write EDGE; a mode change then forces the bit clear.
    always_comb begin
        pend_d = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (edge_q[i])
                pend_d[i] = rise[i] | (pend_q[i] & ~w1c[i]);
            else
                pend_d[i] = src[i];
            if (mode_chg[i]) pend_d[i] = 1'b0;
        end
    end

    always_comb begin
        di_d  = di_q;
        sel_d = sel_q;
        if (RDY) begin
            sel_d = rd;
            di_d  = '0;
            if (rd) begin
                unique case (ridx)
                    R_PEND:   di_d = pend_q;
                    R_ENABLE: di_d = enable_q;
                    R_EDGE:   di_d = edge_q;
                    R_STATUS: di_d = status;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            pend_q     <= '0;
            enable_q   <= RESET_ENABLE;
            edge_q     <= '0;
            src_q      <= '1;
            nmi_q      <= 1'b1;
            nmi_pend_q <= 1'b0;
            di_q       <= '0;
            sel_q      <= 1'b0;
            irq_q      <= 1'b0;
            nmi_out_q  <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            enable_q   <= enable_d;
            edge_q     <= edge_d;
            src_q      <= src;
            nmi_q      <= nmi_src;
            nmi_pend_q <= nmi_pend_d;
            di_q       <= di_d;
            sel_q      <= sel_d;
            irq_q      <= |act;
            nmi_out_q  <= nmi_pend_q;
        end
    end

    assign DI  = di_q;
    assign sel = sel_q;
    assign IRQ = irq_q;
    assign NMI = nmi_out_q;

endmodule

// File: tb/tb_irq_ctl.sv
// Directed bench for irq_ctl: a cycle-by-cycle vector table from reset, then
// hand-written sequences for W1C/rise collision, reset mid-access and NMI through reset.
module tb_irq_ctl;

    logic        clk = 1'b0;
    logic        RST;
    logic [15:0] AD;
    logic [7:0]  DO;
    logic        WE;
    logic        RDY;
    logic [7:0]  src;
    logic        nmi_src;
    logic [7:0]  DI;
    logic        sel;
    logic        IRQ;
    logic        NMI;

    int checks   = 0;
    int failures = 0;

    irq_ctl #(
        .BASE         (16'hFE00),
        .RESET_ENABLE (8'h00)
    ) dut (
        .clk     (clk),
        .RST     (RST),
        .AD      (AD),
        .DO      (DO),
        .WE      (WE),
        .RDY     (RDY),
        .src     (src),
        .nmi_src (nmi_src),
        .DI      (DI),
        .sel     (sel),
        .IRQ     (IRQ),
        .NMI     (NMI)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ad;
        logic [7:0]  wdat;
        logic        we;
        logic        rdy;
        logic [7:0]  src;
        logic        nmi;
        logic        e_irq;
        logic        e_nmi;
        logic        e_sel;
        logic [7:0]  e_di;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vec [NVEC];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic w,
                       input logic r, input logic [7:0] s, input logic n);
        AD = a; DO = d; WE = w; RDY = r; src = s; nmi_src = n;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic ei, input logic en,
                            input logic es, input logic [7:0] ed);
        chk({tag, ".IRQ"}, {7'd0, IRQ}, {7'd0, ei});
        chk({tag, ".NMI"}, {7'd0, NMI}, {7'd0, en});
        chk({tag, ".sel"}, {7'd0, sel}, {7'd0, es});
        chk({tag, ".DI"},  DI, ed);
    endtask

    initial begin
        //            ad        wdat   we    rdy   src    nmi   irq   nmi   sel   di
        vec[0]  = '{16'hFE01, 8'h05, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vec[1]  = '{16'hFE01, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05};
        vec[2]  = '{16'hFE00, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b1, 8'h04};
        vec[3]  = '{16'h0000, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vec[4]  = '{16'hFE00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        vec[5]  = '{16'hFE02, 8'h01, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vec[6]  = '{16'hFE01, 8'h01, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vec[7]  = '{16'h0000, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vec[8]  = '{16'h0000, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vec[9]  = '{16'hFE00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01};
        vec[10] = '{16'hFE00, 8'h01, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vec[11] = '{16'h0000, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vec[12] = '{16'hFE02, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vec[13] = '{16'hFE01, 8'h28, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vec[14] = '{16'h0000, 8'h00, 1'b0, 1'b1, 8'h28, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vec[15] = '{16'hFE03, 8'h00, 1'b0, 1'b1, 8'h28, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0B};
        vec[16] = '{16'hFE04, 8'h00, 1'b0, 1'b1, 8'h28, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vec[17] = '{16'hFE01, 8'h00, 1'b0, 1'b1, 8'h28, 1'b0, 1'b1, 1'b0, 1'b1, 8'h28};
        vec[18] = '{16'hFE01, 8'hFF, 1'b1, 1'b0, 8'h28, 1'b0, 1'b1, 1'b0, 1'b1, 8'h28};
        vec[19] = '{16'hFE01, 8'h00, 1'b0, 1'b1, 8'h28, 1'b0, 1'b1, 1'b0, 1'b1, 8'h28};
        vec[20] = '{16'h0000, 8'h00, 1'b0, 1'b1, 8'h28, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vec[21] = '{16'h0000, 8'h00, 1'b0, 1'b1, 8'h28, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vec[22] = '{16'hFE03, 8'h00, 1'b0, 1'b1, 8'h28, 1'b0, 1'b1, 1'b1, 1'b1, 8'h8B};
        vec[23] = '{16'hFE03, 8'h80, 1'b1, 1'b1, 8'h28, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        vec[24] = '{16'h0000, 8'h00, 1'b0, 1'b1, 8'h28, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vec[25] = '{16'hFE02, 8'hF7, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vec[26] = '{16'hFE00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h20};

        RST = 1'b1;
        cyc(16'h0000, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        cyc(16'h0000, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 8'h00);
        RST = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            cyc(vec[i].ad, vec[i].wdat, vec[i].we, vec[i].rdy, vec[i].src, vec[i].nmi);
            chk_outs($sformatf("vec%0d", i), vec[i].e_irq, vec[i].e_nmi, vec[i].e_sel, vec[i].e_di);
        end

        // W1C of PEND[0] in the same cycle as a new rise on src[0]: set wins.
        // PEND before: 8'h20 (bit3 now level mode, src low).
        cyc(16'hFE00, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0);
        cyc(16'hFE00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        chk("w1c_vs_rise.DI", DI, 8'h21);
        chk("w1c_vs_rise.sel", {7'd0, sel}, 8'h01);
        chk("irq_before_rst", {7'd0, IRQ}, 8'h01);

        // Reset during a write of ENABLE: the write is discarded.
        RST = 1'b1;
        cyc(16'hFE01, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b1);
        chk_outs("rst_mid", 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(16'h0000, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1);
        RST = 1'b0;

        // nmi_src held high through reset release creates no edge.
        cyc(16'hFE01, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1);
        chk("enable_after_rst", DI, 8'h00);
        cyc(16'hFE03, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1);
        chk("status_no_nmi", DI, 8'h00);
        cyc(16'h0000, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1);
        chk("nmi_held_rst", {7'd0, NMI}, 8'h00);
        chk("irq_after_rst", {7'd0, IRQ}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
